// File: rtl/block_selector_if.sv
// Bus bundle for block_selector: pixel stream in, shadow-table write port,
// and the delayed pixel plus selected-block fields out.
//
// Handshake: there is no backpressure. wr_valid_in is a single-cycle write
// strobe; every cycle the write is accepted unconditionally. clear_in and
// frame_start_in are one-cycle pulses. Pixels enter at one per cycle and
// leave 3 cycles later without stalls.
interface block_selector_if #(
  parameter int NUM_BLOCKS = 8
);
  localparam int IDX_W = (NUM_BLOCKS > 1) ? $clog2(NUM_BLOCKS) : 1;

  // Pixel stream in
  logic [10:0]      x_in;
  logic [9:0]       y_in;
  logic             frame_start_in;

  // Shadow-table write port
  logic             wr_valid_in;
  logic [IDX_W-1:0] wr_index_in;
  logic [11:0]      wr_x_in;
  logic [11:0]      wr_y_in;
  logic [13:0]      wr_z_in;
  logic             wr_color_in;
  logic [2:0]       wr_direction_in;
  logic             wr_visible_in;
  logic             clear_in;

  // Delayed pixel and selected block out
  logic [10:0]      x_out;
  logic [9:0]       y_out;
  logic [11:0]      block_x;
  logic [11:0]      block_y;
  logic [13:0]      block_z;
  logic             block_color;
  logic [2:0]       block_direction;
  logic             block_visible;

  // Design side
  modport slave (
    input  x_in, y_in, frame_start_in,
    input  wr_valid_in, wr_index_in, wr_x_in, wr_y_in, wr_z_in,
    input  wr_color_in, wr_direction_in, wr_visible_in, clear_in,
    output x_out, y_out, block_x, block_y, block_z,
    output block_color, block_direction, block_visible
  );

  // Game-logic / pixel-source side
  modport master (
    output x_in, y_in, frame_start_in,
    output wr_valid_in, wr_index_in, wr_x_in, wr_y_in, wr_z_in,
    output wr_color_in, wr_direction_in, wr_visible_in, clear_in,
    input  x_out, y_out, block_x, block_y, block_z,
    input  block_color, block_direction, block_visible
  );
endinterface

// File: rtl/block_selector.sv
// Per-pixel nearest-block lookup. A shadow table is written during the frame
// and copied into the active table on frame_start. Each pixel goes through a
// 3-stage pipeline: register pixel, compute hit vector against the active
// table, pick the nearest (minimum z, lowest index on ties) hit.
module block_selector #(
  parameter int NUM_BLOCKS = 8,
  parameter int MAX_HALF   = 64,
  parameter int MIN_HALF   = 8,
  parameter int Z_SHIFT    = 6
) (
  input  logic          clk_in,
  input  logic          rst_in,
  block_selector_if.slave bus
);

  localparam int IDX_W  = (NUM_BLOCKS > 1) ? $clog2(NUM_BLOCKS) : 1;
  localparam int HALF_W = $clog2(MAX_HALF + 1);

  // Fields the renderer sees for the selected block.
  typedef struct packed {
    logic [11:0] x;
    logic [11:0] y;
    logic [13:0] z;
    logic        color;
    logic [2:0]  dir;
  } fields_t;

  // A table entry: renderer fields plus lookup-only data.
  typedef struct packed {
    logic              valid;
    logic [HALF_W-1:0] half;
    fields_t           f;
  } entry_t;

  entry_t  shadow_q    [NUM_BLOCKS];
  entry_t  shadow_d    [NUM_BLOCKS];
  entry_t  active_q    [NUM_BLOCKS];
  // Copy of the renderer fields taken alongside the hit vector, so a swap
  // landing between S2 and S3 cannot change what an in-flight pixel selects.
  fields_t fields_s3_q [NUM_BLOCKS];

  logic [13:0]       z_shift_w;
  logic [HALF_W-1:0] wr_half_w;

  logic [10:0]           x1_q, x2_q;
  logic [9:0]            y1_q, y2_q;
  logic [NUM_BLOCKS-1:0] hit_d, hit_q;

  logic             found_w;
  logic [IDX_W-1:0] sel_w;

  logic [10:0] x_out_q;
  logic [9:0]  y_out_q;
  fields_t     blk_q;
  logic        vis_q;

  // Absolute value of a 13-bit signed distance (never -4096 here).
  function automatic logic [12:0] abs13(input logic signed [12:0] v);
    return v[12] ? 13'(-v) : 13'(v);
  endfunction

  // Whether an active entry's projected square covers the pixel.
  function automatic logic covers(input entry_t e, input logic [10:0] px,
                                  input logic [9:0] py);
    logic signed [12:0] dx;
    logic signed [12:0] dy;
    logic [12:0]        lim;
    dx  = $signed({2'b00, px}) - $signed({1'b0, e.f.x});
    dy  = $signed({3'b000, py}) - $signed({1'b0, e.f.y});
    lim = {{(13 - HALF_W){1'b0}}, e.half};
    return e.valid && (abs13(dx) <= lim) && (abs13(dy) <= lim);
  endfunction

  // Projected half-size for the incoming write, clamped without underflow.
  always_comb begin
    z_shift_w = bus.wr_z_in >> Z_SHIFT;
    if (z_shift_w >= 14'(MAX_HALF - MIN_HALF)) begin
      wr_half_w = HALF_W'(MIN_HALF);
    end else begin
      wr_half_w = HALF_W'(14'(MAX_HALF) - z_shift_w);
    end
  end

  // Next shadow contents: clear first, then a same-cycle write overrides it.
  always_comb begin
    for (int i = 0; i < NUM_BLOCKS; i++) begin
      shadow_d[i] = shadow_q[i];
      if (bus.clear_in) begin
        shadow_d[i].valid = 1'b0;
      end
    end
    if (bus.wr_valid_in) begin
      shadow_d[bus.wr_index_in].valid   = bus.wr_visible_in;
      shadow_d[bus.wr_index_in].half    = wr_half_w;
      shadow_d[bus.wr_index_in].f.x     = bus.wr_x_in;
      shadow_d[bus.wr_index_in].f.y     = bus.wr_y_in;
      shadow_d[bus.wr_index_in].f.z     = bus.wr_z_in;
      shadow_d[bus.wr_index_in].f.color = bus.wr_color_in;
      shadow_d[bus.wr_index_in].f.dir   = bus.wr_direction_in;
    end
  end

  // Shadow table update and frame-start copy into the active table.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int i = 0; i < NUM_BLOCKS; i++) begin
        shadow_q[i] <= '0;
        active_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_BLOCKS; i++) begin
        shadow_q[i] <= shadow_d[i];
        if (bus.frame_start_in) begin
          active_q[i] <= shadow_d[i];
        end
      end
    end
  end

  // S2 combinational: coverage test of the S1 pixel against every entry.
  always_comb begin
    hit_d = '0;
    for (int i = 0; i < NUM_BLOCKS; i++) begin
      hit_d[i] = covers(active_q[i], x1_q, y1_q);
    end
  end

  // S1 and S2 registers: pixel, hit vector and the matching field snapshot.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      x1_q  <= '0;
      y1_q  <= '0;
      x2_q  <= '0;
      y2_q  <= '0;
      hit_q <= '0;
      for (int i = 0; i < NUM_BLOCKS; i++) begin
        fields_s3_q[i] <= '0;
      end
    end else begin
      x1_q  <= bus.x_in;
      y1_q  <= bus.y_in;
      x2_q  <= x1_q;
      y2_q  <= y1_q;
      hit_q <= hit_d;
      for (int i = 0; i < NUM_BLOCKS; i++) begin
        fields_s3_q[i] <= active_q[i].f;
      end
    end
  end

  // S3 combinational: nearest hit; strict compare keeps the lowest index.
  always_comb begin
    found_w = 1'b0;
    sel_w   = '0;
    for (int i = 0; i < NUM_BLOCKS; i++) begin
      if (hit_q[i] && (!found_w || (fields_s3_q[i].z < fields_s3_q[sel_w].z))) begin
        found_w = 1'b1;
        sel_w   = IDX_W'(i);
      end
    end
  end

  // S3 registers: outputs, with all block fields forced to 0 on a miss.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      x_out_q <= '0;
      y_out_q <= '0;
      blk_q   <= '0;
      vis_q   <= 1'b0;
    end else begin
      x_out_q <= x2_q;
      y_out_q <= y2_q;
      blk_q   <= found_w ? fields_s3_q[sel_w] : '0;
      vis_q   <= found_w;
    end
  end

  assign bus.x_out           = x_out_q;
  assign bus.y_out           = y_out_q;
  assign bus.block_x         = blk_q.x;
  assign bus.block_y         = blk_q.y;
  assign bus.block_z         = blk_q.z;
  assign bus.block_color     = blk_q.color;
  assign bus.block_direction = blk_q.dir;
  assign bus.block_visible   = vis_q;

endmodule

// File: doc/block_selector.md
Name: block_selector

Overview:
- Per-pixel block lookup stage that sits directly upstream of the block renderer.
- Holds a double-buffered table of up to NUM_BLOCKS note blocks, loaded by the game logic during a frame and made active at frame start.
- For every pixel it finds the nearest block (smallest z) whose projected square covers the pixel. It then presents that block's fields, aligned with the delayed pixel coordinates, to the renderer.

Parameters:
- NUM_BLOCKS, 8, table entries; power of two, 2..16.
- MAX_HALF, 64, projected half-size in pixels at z=0.
- MIN_HALF, 8, minimum projected half-size.
- Z_SHIFT, 6, depth attenuation shift: half = MAX_HALF - (z >> Z_SHIFT), clamped to MIN_HALF.

Ports:
- clk_in  in  1  system clock.
- rst_in  in  1  synchronous active-high reset.
- x_in  in  11  current pixel x.
- y_in  in  10  current pixel y.
- frame_start_in  in  1  one-cycle pulse; swaps shadow table into active table.
- wr_valid_in  in  1  write strobe into shadow table.
- wr_index_in  in  $clog2(NUM_BLOCKS)  shadow entry index.
- wr_x_in  in  12  block centre x.
- wr_y_in  in  12  block centre y.
- wr_z_in  in  14  block depth; smaller is nearer.
- wr_color_in  in  1  0=blue, 1=red.
- wr_direction_in  in  3  0 up, 1 right, 2 down, 3 left, 4 any.
- wr_visible_in  in  1  entry is visible.
- clear_in  in  1  invalidates all shadow entries.
- x_out  out  11  x_in delayed by 3 cycles.
- y_out  out  10  y_in delayed by 3 cycles.
- block_x  out  12  selected block x.
- block_y  out  12  selected block y.
- block_z  out  14  selected block z.
- block_color  out  1  selected block colour.
- block_direction  out  3  selected block direction.
- block_visible  out  1  1 when a block covers the pixel.

Behaviour:
- Reset:
  - All outputs are 0.
  - All shadow and active entries are invalid.
  - Pipeline registers are cleared.
  - Takes effect on any cycle, including mid-frame; the first 3 post-reset cycles output block_visible=0.
- Shadow write:
  - When wr_valid_in=1, the entry at wr_index_in stores all wr_* fields plus its half-size, computed at write time.
  - The entry's valid bit is set to wr_visible_in.
  - Half-size arithmetic:
    - s = wr_z_in >> Z_SHIFT.
    - If s >= MAX_HALF - MIN_HALF, half = MIN_HALF; otherwise half = MAX_HALF - s.
    - No unsigned underflow is permitted.
- clear_in=1 clears all shadow valid bits. If wr_valid_in is high in the same cycle, the write wins for wr_index_in.
- Swap:
  - On frame_start_in=1, the whole shadow table, including any same-cycle write or clear result, is copied into the active table at the clock edge.
  - The shadow table keeps its contents after the swap.
  - Writes never alter the active table directly.
- Lookup pipeline, fixed latency 3 cycles, one pixel per cycle, no stalls:
  - S1: register x_in and y_in.
  - S2: per active entry, compute dx = x - bx and dy = y - by as signed 13-bit values, with x/y zero-extended.
    - hit = valid && |dx| <= half && |dy| <= half.
    - Register the hit vector and coordinates.
  - S3: select the hit entry with minimum z; ties go to the lowest index.
    - Register its fields to the outputs with block_visible=1.
    - If there are no hits, block_visible=0 and block_x, block_y, block_z, block_color and block_direction are driven to 0.
- S2 uses the active table as of that cycle. A swap mid-pipeline affects only pixels whose S2 occurs after the swap edge.
- Blocks partially off-screen (bx < half) are handled by signed compare; there is no wrap.

Test Plan:
- Write entry 0 (x=100, y=100, z=0, visible) then pulse frame_start; pixel (164,100) -> 3 cycles later block_visible=1, block_x=100. Pixel (165,100) -> block_visible=0.
- Entry 0 as above plus entry 1 (120,100, z=1024, half 48); pixel (110,100) -> block_z=0, entry 0 wins. Set entry 0 z=2048 and swap -> entry 1 (block_x=120) wins.
- Entries 2 and 5 identical except colour (2 blue, 5 red), same z -> block_color=0 (index 2).
- Entry with z=4000 -> half=8; pixel offset dx=8 hits, dx=9 misses.
- Write entry 3 without frame_start -> never visible. After frame_start -> visible. clear_in, then frame_start -> block_visible=0 everywhere.
- Assert rst_in mid-frame with active blocks -> outputs 0 next cycle, block_visible=0 until new writes plus frame_start.
